// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared types and constants for the VGA frame path: fetch FSM
//               state type, 640x480 frame geometry and the memory arbiter
//               slot encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Frame geometry (8-bit pixels, one byte per pixel)
  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int FRAME_BYTES = H_ACTIVE * V_ACTIVE;  // 307200

  // Memory arbiter source slots; the frame fetcher owns slot 1
  localparam logic [1:0] ARB_SLOT_CPU   = 2'd0;
  localparam logic [1:0] ARB_SLOT_FETCH = 2'd1;
  localparam logic [1:0] ARB_SLOT_BLIT  = 2'd2;
  localparam logic [1:0] ARB_SLOT_SPARE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2,
    ST_FLUSH  = 2'd3
  } fetch_state_t;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO. Pointers carry one
//               extra wrap bit so full/empty come from an MSB compare.
// Ports       : clk, rst (async, active high), flush (sync clear),
//               push/wdata, pop/rdata (head byte, 0 when empty),
//               full, empty, level (0..FIFODEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DWIDTH    = 8,
  parameter int FIFODEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [DWIDTH-1:0]            wdata,
  input  logic                         pop,
  output logic [DWIDTH-1:0]            rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(FIFODEPTH):0]   level
);

  localparam int PW = $clog2(FIFODEPTH);

  logic [PW:0]       wr_ptr;
  logic [PW:0]       rd_ptr;
  logic [DWIDTH-1:0] mem [FIFODEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign rdata = empty ? '0 : mem[rd_ptr[PW-1:0]];

  // A push into a full FIFO is legal when the head leaves in the same cycle
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Storage needs no reset; the pointers decide what is visible
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/vram_fetch.sv
`default_nettype none
// ============================================================================
// Module      : vram_fetch
// Description : Frame prefetcher between the memory arbiter (read slot 1) and
//               the pixel stage. Reads arrive unsolicited; accepted bytes
//               advance ReqAddr, rejected ones leave it so the byte is re-read.
// Ports       : MemClk, Reset (async, active high), FrameStart,
//               ReqAddr / ReadData / ReadDataRdy  (arbiter side),
//               PixData / PixValid / PixReq       (pixel side),
//               Underflow (sticky), UnderflowCount (optional)
// Config      : `define VRAM_FETCH_UFCNT_EN adds the 16-bit saturating
//               UnderflowCount output.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_fetch
  import vga_pkg::*;
#(
  parameter int AWIDTH    = 19,
  parameter int DWIDTH    = 8,
  parameter int FIFODEPTH = 16,
  parameter int FRAMESIZE = FRAME_BYTES,
  parameter int BASEADDR  = 0
) (
  input  logic              MemClk,
  input  logic              Reset,
  input  logic              FrameStart,
  output logic [AWIDTH-1:0] ReqAddr,
  input  logic [DWIDTH-1:0] ReadData,
  input  logic              ReadDataRdy,
  output logic [DWIDTH-1:0] PixData,
  output logic              PixValid,
  input  logic              PixReq,
  output logic              Underflow
`ifdef VRAM_FETCH_UFCNT_EN
  ,
  output logic [15:0]       UnderflowCount
`endif
);

  localparam int                CW         = $clog2(FRAMESIZE + 1);
  localparam int                LW         = $clog2(FIFODEPTH) + 1;
  localparam logic [AWIDTH-1:0] ADDR_FIRST = AWIDTH'(BASEADDR);
  localparam logic [AWIDTH-1:0] ADDR_LAST  = AWIDTH'(BASEADDR + FRAMESIZE - 1);
  localparam logic [CW-1:0]     FRAME_CNT  = CW'(FRAMESIZE);
  localparam logic [LW-1:0]     FULL_LEVEL = LW'(FIFODEPTH);

  fetch_state_t  state;
  logic [CW-1:0] fetched;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic          write_window;
  logic          push;
  logic          pop;
  logic          uf_event;

  // Writes stop once the whole frame has been fetched, even for the one
  // cycle STREAM lingers before moving to FLUSH.
  assign write_window = ((state == ST_PRIME) || (state == ST_STREAM)) && (fetched != FRAME_CNT);
  assign PixValid     = ((state == ST_STREAM) || (state == ST_FLUSH)) && !fifo_empty;
  // FrameStart wins over both a pop and an arriving strobe
  assign pop          = PixReq && PixValid && !FrameStart;
  assign push         = ReadDataRdy && write_window && !FrameStart && (!fifo_full || pop);
  assign uf_event     = PixReq && !PixValid && (state == ST_STREAM) && !FrameStart;

  sync_fifo #(
    .DWIDTH    (DWIDTH),
    .FIFODEPTH (FIFODEPTH)
  ) u_fifo (
    .clk   (MemClk),
    .rst   (Reset),
    .flush (FrameStart),
    .push  (push),
    .wdata (ReadData),
    .pop   (pop),
    .rdata (PixData),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge MemClk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      ReqAddr   <= ADDR_FIRST;
      fetched   <= '0;
      Underflow <= 1'b0;
    end else if (FrameStart) begin
      state     <= ST_PRIME;
      ReqAddr   <= ADDR_FIRST;
      fetched   <= '0;
      Underflow <= 1'b0;
    end else begin
      if (push) begin
        ReqAddr <= (ReqAddr == ADDR_LAST) ? ADDR_FIRST : ReqAddr + AWIDTH'(1);
        fetched <= fetched + CW'(1);
      end
      if (uf_event) Underflow <= 1'b1;
      case (state)
        ST_PRIME:  if (fifo_level == FULL_LEVEL) state <= ST_STREAM;
        ST_STREAM: if (fetched == FRAME_CNT)     state <= ST_FLUSH;
        ST_FLUSH:  if (fifo_empty)               state <= ST_IDLE;
        default:   state <= state;
      endcase
    end
  end

`ifdef VRAM_FETCH_UFCNT_EN
  // Lifetime statistic: survives FrameStart, cleared only by Reset
  always_ff @(posedge MemClk or posedge Reset) begin
    if (Reset) begin
      UnderflowCount <= '0;
    end else if (uf_event && (UnderflowCount != 16'hFFFF)) begin
      UnderflowCount <= UnderflowCount + 16'd1;
    end
  end
`endif

endmodule : vram_fetch
`default_nettype wire

// File: tb/tb_vram_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_fetch
// Description : Self-checking bench for vram_fetch (FRAMESIZE=32): directed
//               scenarios followed by random traffic, all compared each cycle
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_fetch;

  localparam int AW    = 19;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int FS    = 32;
  localparam int BASE  = 0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fs = 1'b0;
  logic          rdy = 1'b0;
  logic          preq = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          uf;
`ifdef VRAM_FETCH_UFCNT_EN
  logic [15:0]   uf_cnt;
`endif

  vram_fetch #(
    .AWIDTH(AW), .DWIDTH(DW), .FIFODEPTH(DEPTH), .FRAMESIZE(FS), .BASEADDR(BASE)
  ) dut (
    .MemClk      (clk),
    .Reset       (rst),
    .FrameStart  (fs),
    .ReqAddr     (req_addr),
    .ReadData    (rdata),
    .ReadDataRdy (rdy),
    .PixData     (pix_data),
    .PixValid    (pix_valid),
    .PixReq      (preq),
    .Underflow   (uf)
`ifdef VRAM_FETCH_UFCNT_EN
    ,
    .UnderflowCount (uf_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_PRIME, M_STREAM, M_FLUSH} mphase_t;
  logic [DW-1:0] q[$];
  mphase_t       m_phase = M_IDLE;
  int            m_cnt   = 0;     // bytes accepted since FrameStart
  bit            m_uf    = 0;
  int            m_ufcnt = 0;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  function automatic bit m_valid();
    return ((m_phase == M_STREAM) || (m_phase == M_FLUSH)) && (q.size() > 0);
  endfunction

  // The fetch address is simply the frame offset of the next byte to accept
  function automatic int m_addr();
    return BASE + (m_cnt % FS);
  endfunction

  task automatic model_update();
    bit v;
    int sz;
    int cnt;
    bit p;
    bit w;
    v   = m_valid();
    sz  = q.size();
    cnt = m_cnt;
    if (rst) begin
      q.delete(); m_phase = M_IDLE; m_cnt = 0; m_uf = 0; m_ufcnt = 0;
    end else if (fs) begin
      q.delete(); m_phase = M_PRIME; m_cnt = 0; m_uf = 0;
    end else begin
      p = preq && v;
      w = rdy && ((m_phase == M_PRIME) || (m_phase == M_STREAM)) && (cnt < FS) && ((sz < DEPTH) || p);
      if (preq && !v && (m_phase == M_STREAM)) begin
        m_uf = 1;
        if (m_ufcnt < 65535) m_ufcnt++;
      end
      if (p) void'(q.pop_front());
      if (w) begin
        q.push_back(rdata);
        m_cnt++;
      end
      case (m_phase)
        M_PRIME:  if (sz == DEPTH) m_phase = M_STREAM;
        M_STREAM: if (cnt == FS)   m_phase = M_FLUSH;
        M_FLUSH:  if (sz == 0)     m_phase = M_IDLE;
        default:  ;
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("pix_valid", {31'd0, pix_valid}, {31'd0, m_valid()});
    check("req_addr", {13'd0, req_addr}, m_addr());
    check("underflow", {31'd0, uf}, {31'd0, m_uf});
    if (q.size() > 0) check("pix_data", {24'd0, pix_data}, {24'd0, q[0]});
`ifdef VRAM_FETCH_UFCNT_EN
    check("uf_count", {16'd0, uf_cnt}, m_ufcnt);
`endif
  endtask

  // One clock: drive on the falling edge, model on the rising edge, check 1ns later
  task automatic step(input bit f, input bit r, input logic [DW-1:0] d, input bit p, input bit res);
    @(negedge clk);
    fs = f; rdy = r; rdata = d; preq = p; rst = res;
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  initial begin
    // Reset state
    step(0, 0, 8'h00, 0, 1);
    step(0, 1, 8'h55, 0, 1);
    check("rst_pix_data", {24'd0, pix_data}, 32'd0);
    check("rst_addr", {13'd0, req_addr}, BASE);

    // Ignored strobes in IDLE after release
    step(0, 1, 8'h77, 0, 0);

    // Prime with 0x00..0x0F
    step(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 8'(i), 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    check("prime_addr", {13'd0, req_addr}, 32'd16);
    check("prime_head", {24'd0, pix_data}, 32'h00);
    check("prime_stream_valid", {31'd0, pix_valid}, 32'd1);

    // Full FIFO drops strobes, address held
    for (int i = 0; i < 3; i++) step(0, 1, 8'($urandom), 0, 0);
    check("full_addr_hold", {13'd0, req_addr}, 32'd16);

    // Whole frame out with simultaneous push/pop, then FLUSH and IDLE
    for (int i = 0; i < 40; i++) step(0, 1, 8'($urandom), 1, 0);
    check("frame_wrap_addr", {13'd0, req_addr}, BASE);
    check("frame_idle_valid", {31'd0, pix_valid}, 32'd0);

    // FrameStart with strobe and pop at level 9
    step(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 8'(8'h20 + i), 0, 0);
    step(1, 1, 8'hAA, 1, 0);
    check("fs_addr", {13'd0, req_addr}, BASE);
    check("fs_valid", {31'd0, pix_valid}, 32'd0);
    for (int i = 0; i < 16; i++) step(0, 1, 8'(8'h40 + i), 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    check("fs_first_byte", {24'd0, pix_data}, 32'h40);

    // Drain and keep requesting: two underflow events
    for (int i = 0; i < 18; i++) step(0, 0, 8'h00, 1, 0);
    check("uf_flag", {31'd0, uf}, 32'd1);
`ifdef VRAM_FETCH_UFCNT_EN
    check("uf_count_two", {16'd0, uf_cnt}, 32'd2);
`endif

    // Reset mid-STREAM at level 7
    step(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 8'($urandom), 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 8'h00, 1, 0);
    step(0, 1, 8'h99, 1, 1);
    check("midrst_data", {24'd0, pix_data}, 32'd0);
    check("midrst_valid", {31'd0, pix_valid}, 32'd0);
    check("midrst_uf", {31'd0, uf}, 32'd0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'($urandom), 1, 0);
    check("midrst_addr", {13'd0, req_addr}, BASE);

    // Random traffic
    step(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_vram_fetch
`default_nettype wire

// File: doc/vram_fetch.md
VRAM_FETCH -- requirements
Module: vram_fetch

Interface
REQ-001 Parameter AWIDTH, default 19: VRAM address width.
REQ-002 Parameter DWIDTH, default 8: VRAM data width.
REQ-003 Parameter FIFODEPTH, default 16: prefetch FIFO depth, power of two.
REQ-004 Parameter FRAMESIZE, default 307200: bytes per frame.
REQ-005 Parameter BASEADDR, default 0: frame start address.
REQ-006 MemClk  input  1  sole clock, shared with the memory arbiter; all logic on the rising edge.
REQ-007 Reset  input  1  asynchronous, active-high reset.
REQ-008 FrameStart  input  1  one-cycle pulse that restarts frame fetch.
REQ-009 ReqAddr  output  AWIDTH  read address to arbiter source 1.
REQ-010 ReadData  input  DWIDTH  byte from arbiter read port 1.
REQ-011 ReadDataRdy  input  1  one-cycle strobe qualifying ReadData.
REQ-012 PixData  output  DWIDTH  FIFO head byte.
REQ-013 PixValid  output  1  PixData valid.
REQ-014 PixReq  input  1  pop request from the pixel stage.
REQ-015 Underflow  output  1  sticky underflow flag (see REQ-031).

Function
REQ-016 Arbiter issues reads without request, so the block SHALL absorb or discard every ReadDataRdy strobe; no back-pressure path exists.
REQ-017 ReqAddr SHALL be registered, held stable between strobes, and SHALL advance by 1 only when a byte is written into the FIFO.
REQ-018 A strobe arriving with the FIFO full, or outside PRIME/STREAM, SHALL be dropped with ReqAddr unchanged, so the same address is re-read.
REQ-019 ReqAddr SHALL wrap from BASEADDR+FRAMESIZE-1 to BASEADDR.
REQ-020 A fetched-byte counter (ceil(log2(FRAMESIZE+1)) bits) SHALL count FIFO writes since the last FrameStart.
REQ-021 FSM states: IDLE, PRIME, STREAM, FLUSH.
REQ-022 IDLE: FIFO writes disabled, PixValid=0; FrameStart -> PRIME.
REQ-023 PRIME: writes enabled, PixValid=0; FIFO level == FIFODEPTH -> STREAM.
REQ-024 STREAM: PixValid = FIFO not empty; fetched count == FRAMESIZE -> FLUSH.
REQ-025 FLUSH: writes disabled, PixValid = not empty; FIFO empty -> IDLE.
REQ-026 Pop occurs when PixReq && PixValid; PixData SHALL show the next byte on the following cycle (first-word-fall-through).
REQ-027 Simultaneous push and pop on a full FIFO SHALL succeed; level unchanged.
REQ-028 FrameStart in any state SHALL, in one cycle, empty the FIFO, set ReqAddr=BASEADDR, clear the counter, and enter PRIME; a strobe in the same cycle is dropped.
REQ-029 FrameStart has priority over PixReq in the same cycle; the pop is ignored.
REQ-030 Write and read pointers SHALL be log2(FIFODEPTH)+1 bits; full/empty SHALL be derived from the MSB compare.
REQ-031 Underflow SHALL set when PixReq=1 and PixValid=0 in STREAM, and clear only on Reset or FrameStart.

Reset
REQ-032 Reset SHALL force: IDLE, FIFO empty, ReqAddr=BASEADDR, counter=0, PixValid=0, PixData=0, Underflow=0.
REQ-033 Reset asserted mid-frame SHALL discard all buffered data; the block resumes only on the next FrameStart after release.

Configuration
REQ-034 Macro VRAM_FETCH_UFCNT_EN defined: add output UnderflowCount (16 bits), incremented on each REQ-031 event, saturating at 0xFFFF, cleared by Reset only.
REQ-035 Macro absent: no UnderflowCount port or counter logic; Underflow behaves identically in both builds.

Structure
REQ-036 Package vga_pkg SHALL hold the FSM state typedef, the frame constants (640x480, 307200), and the arbiter slot-encoding constants.
REQ-037 FIFO storage and pointer logic SHALL be the sub-module sync_fifo (parameters DWIDTH, FIFODEPTH; ports push, pop, flush, full, empty, level).

Verification
REQ-038 Reset, FrameStart, 16 strobes with bytes 0x00..0x0F, PixReq=0 -> PRIME to STREAM after the 16th; ReqAddr=16; PixData=0x00.
REQ-039 FIFO full, 3 more strobes -> bytes dropped; ReqAddr stays 16; level 16.
REQ-040 FRAMESIZE=32, continuous strobes and PixReq -> 32 bytes out in order; FLUSH then IDLE; ReqAddr wraps to 0.
REQ-041 FrameStart asserted with ReadDataRdy and PixReq at level 9 -> level 0, PRIME, ReqAddr=BASEADDR, strobe byte absent from output.
REQ-042 STREAM with FIFO empty, PixReq=1 for 2 cycles -> Underflow=1; with VRAM_FETCH_UFCNT_EN, UnderflowCount=2.
REQ-043 Reset pulsed mid-STREAM at level 7 -> all outputs at REQ-032 values; strobes ignored until FrameStart.
